// File: rtl/serializer_16.sv
// serializer_16: MSB-first parallel-to-serial converter for words of 3..16 valid bits
// Ports:
//   clk_i, rst_i      clock and synchronous active-high reset
//   data_i            parallel word, bit DATA_W-1 leaves first
//   data_mod_i        valid bit count, 0 encodes 16; counts 1 and 2 drop the word
//   data_val_i        word strobe, only looked at while idle
//   ser_data_o        serial bit, 0 whenever no bit is valid
//   ser_data_val_o    serial bit valid
//   busy_o            word in flight, identical to ser_data_val_o
module serializer_16 #(
   parameter int DATA_W = 16,
   parameter int MOD_W  = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [MOD_W-1:0]  data_mod_i,
   input  logic              data_val_i,
   output logic              ser_data_o,
   output logic              ser_data_val_o,
   output logic              busy_o
);
   localparam int CNT_W = MOD_W + 1;
   typedef enum logic {IDLE, SHIFT} state_t;
   state_t            state, state_n;
   logic [DATA_W-1:0] sh, sh_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic              accept;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         sh    <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         sh    <= sh_n;
         cnt   <= cnt_n;
      end
   end
   always_comb begin
      accept  = data_val_i && data_mod_i != MOD_W'(1) && data_mod_i != MOD_W'(2);
      state_n = state;
      sh_n    = sh;
      cnt_n   = cnt;
      if (state == IDLE) begin
         if (accept) begin
            state_n = SHIFT;
            sh_n    = data_i;
            cnt_n   = (data_mod_i == '0) ? CNT_W'(DATA_W) : {1'b0, data_mod_i};
         end
      end else begin
         sh_n  = sh << 1;
         cnt_n = cnt - CNT_W'(1);
         // Clearing the register on the last bit keeps ser_data_o at 0 while idle,
         // so the serial output can come straight from the register MSB.
         if (cnt == CNT_W'(1)) begin
            state_n = IDLE;
            sh_n    = '0;
         end
      end
   end
   assign ser_data_val_o = (state == SHIFT);
   assign busy_o         = ser_data_val_o;
   assign ser_data_o     = sh[DATA_W-1];
endmodule
